vga_write_arbiter: RTL and testbench

//   Shares the single VGA adapter pixel-write port among NUM_REQ sprite drawers
//   (player car, obstacles, lane/background painter). Each drawer requests the

---
 rtl/vga_write_arbiter_if.sv | 30 +++
 rtl/vga_write_arbiter.sv | 139 +++++++++++++
 tb/tb_vga_write_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_write_arbiter_if.sv
// vga_write_arbiter_if: drawer-side request/pixel lanes and adapter-side outputs of the VGA write arbiter
//   master: drives req, wr_x, wr_y, wr_color, wr_en; observes grant, VGA_*, collision, timeout
//   slave : the arbiter
interface vga_write_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*nX-1:0]          wr_x;
  logic [NUM_REQ*nY-1:0]          wr_y;
  logic [NUM_REQ*COLOR_DEPTH-1:0] wr_color;
  logic [NUM_REQ-1:0]             wr_en;
  logic [NUM_REQ-1:0]             grant;
  logic [nX-1:0]                  VGA_x;
  logic [nY-1:0]                  VGA_y;
  logic [COLOR_DEPTH-1:0]         VGA_color;
  logic                           VGA_write;
  logic                           collision;
  logic                           timeout;
  modport master (
    output req, wr_x, wr_y, wr_color, wr_en,
    input  grant, VGA_x, VGA_y, VGA_color, VGA_write, collision, timeout
  );
  modport slave (
    input  req, wr_x, wr_y, wr_color, wr_en,
    output grant, VGA_x, VGA_y, VGA_color, VGA_write, collision, timeout
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin owner of the single VGA adapter write port among NUM_REQ sprite drawers
//   clk, rst : clock, synchronous active-high reset
//   bus      : vga_write_arbiter_if.slave (requests + packed pixel lanes in; grant, VGA_*, collision, timeout out)
//   Optional: define VGA_ARB_TIMEOUT_EN to revoke ownership after MAX_HOLD owned cycles.
module vga_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int MAX_HOLD    = 4096
) (
  input logic clk,
  input logic rst,
  vga_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, OWN} state_t;
  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d, elig, fwd;
  logic [IW-1:0]          rr_q, rr_d, win;
  logic                   found;
  logic [nX-1:0]          vga_x_q, vga_x_d;
  logic [nY-1:0]          vga_y_q, vga_y_d;
  logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
  logic                   vga_write_q, vga_write_d;
  logic                   collision_q, collision_d;
`ifdef VGA_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_REQ-1:0]     mask_q, mask_d;
  logic                   timeout_q, timeout_d;
  // a revoked drawer stays ineligible until it lets go of req once
  assign elig = bus.req & ~mask_q;
`else
  assign elig = bus.req;
`endif
  // round-robin pick: first eligible lane after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
`ifdef VGA_ARB_TIMEOUT_EN
    mask_d    = mask_q & bus.req;
    timeout_d = 1'b0;
    hold_d    = (state_q == OWN) ? hold_q + HW'(1) : '0;
`endif
    if (state_q == IDLE) begin
      if (found) begin
        grant_d = NUM_REQ'(1) << win;
        rr_d    = win;
        state_d = OWN;
      end
    end else if (!bus.req[rr_q]) begin
      grant_d = '0;
      state_d = IDLE;
    end
`ifdef VGA_ARB_TIMEOUT_EN
    else if (hold_q == HW'(MAX_HOLD - 1)) begin
      grant_d       = '0;
      state_d       = IDLE;
      timeout_d     = 1'b1;
      mask_d[rr_q]  = 1'b1;
    end
`endif
  end
  // only the registered owner's strobe reaches the adapter; any other strobe is a collision
  always_comb begin
    fwd         = bus.wr_en & grant_q;
    vga_write_d = |fwd;
    collision_d = collision_q | |(bus.wr_en & ~grant_q);
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fwd[i]) begin
        vga_x_d     = bus.wr_x[i*nX +: nX];
        vga_y_d     = bus.wr_y[i*nY +: nY];
        vga_color_d = bus.wr_color[i*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= IW'(NUM_REQ - 1);
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
      collision_q <= collision_d;
    end
  end
`ifdef VGA_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  // ownership is unbounded, so a forced revoke can never happen
  assign bus.timeout = (MAX_HOLD < 0);
`endif
  assign bus.grant     = grant_q;
  assign bus.VGA_x     = vga_x_q;
  assign bus.VGA_y     = vga_y_q;
  assign bus.VGA_color = vga_color_q;
  assign bus.VGA_write = vga_write_q;
  assign bus.collision = collision_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed self-checking bench for vga_write_arbiter
module tb_vga_write_arbiter;
  localparam int NR = 4, NX = 10, NY = 9, CD = 9;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vga_write_arbiter_if #(.NUM_REQ(NR), .nX(NX), .nY(NY), .COLOR_DEPTH(CD)) bus ();
  vga_write_arbiter #(.NUM_REQ(NR), .nX(NX), .nY(NY), .COLOR_DEPTH(CD), .MAX_HOLD(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_lane(input int i, input logic en, input logic [NX-1:0] x,
                          input logic [NY-1:0] y, input logic [CD-1:0] c);
    bus.wr_en[i]            = en;
    bus.wr_x[i*NX +: NX]    = x;
    bus.wr_y[i*NY +: NY]    = y;
    bus.wr_color[i*CD +: CD] = c;
  endtask
  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.wr_en = '0;
    for (int i = 0; i < NR; i++) set_lane(i, 1'b0, 10'h3FF, 9'h1FF, 9'h1FF);
    step(2);
    rst = 1'b0;
  endtask
  initial begin
    bus.req = '0; bus.wr_en = '0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = '0;
    do_reset();
    chk("rst_grant", bus.grant, 0);
    chk("rst_write", bus.VGA_write, 0);
    chk("rst_x", bus.VGA_x, 0);
    chk("rst_coll", bus.collision, 0);
    chk("rst_tmo", bus.timeout, 0);
    // single requester, one pixel
    bus.req = 4'b0010;
    step();
    chk("t2_grant", bus.grant, 4'b0010);
    set_lane(1, 1'b1, 10'd5, 9'd7, 9'h1C7);
    chk("t2_nowrite_yet", bus.VGA_write, 0);
    step();
    chk("t2_write", bus.VGA_write, 1);
    chk("t2_x", bus.VGA_x, 5);
    chk("t2_y", bus.VGA_y, 7);
    chk("t2_color", bus.VGA_color, 9'h1C7);
    set_lane(1, 1'b0, 10'd5, 9'd7, 9'h1C7);
    step();
    chk("t2_write_off", bus.VGA_write, 0);
    chk("t2_coll", bus.collision, 0);
    // reset mid-burst clears collision and grant
    bus.wr_en[3] = 1'b1;
    step();
    chk("t1_coll_set", bus.collision, 1);
    bus.wr_en[3] = 1'b0;
    bus.wr_en[1] = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("t1_grant", bus.grant, 0);
    chk("t1_write", bus.VGA_write, 0);
    chk("t1_coll", bus.collision, 0);
    // two simultaneous, lowest wins after reset; last pixel forwarded on release
    do_reset();
    bus.req = 4'b0101;
    step();
    chk("t3_grant0", bus.grant, 4'b0001);
    step();
    chk("t3_hold0", bus.grant, 4'b0001);
    bus.req[0] = 1'b0;
    set_lane(0, 1'b1, 10'd9, 9'd3, 9'h011);
    step();
    set_lane(0, 1'b0, 10'd9, 9'd3, 9'h011);
    chk("t3_gap", bus.grant, 0);
    chk("t3_last_write", bus.VGA_write, 1);
    chk("t3_last_x", bus.VGA_x, 9);
    step();
    chk("t3_grant2", bus.grant, 4'b0100);
    chk("t3_write_off", bus.VGA_write, 0);
    // full round robin with 3-pixel bursts
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      int o;
      o = n % NR;
      chk($sformatf("t4_grant%0d", n), bus.grant, 32'd1 << o);
      for (int p = 0; p < 3; p++) begin
        set_lane(o, 1'b1, 10'(o*100 + p), 9'(o*10 + p), 9'(o*8 + p));
        step();
        chk($sformatf("t4_x%0d_%0d", n, p), bus.VGA_x, o*100 + p);
        chk($sformatf("t4_y%0d_%0d", n, p), bus.VGA_y, o*10 + p);
        chk($sformatf("t4_w%0d_%0d", n, p), bus.VGA_write, 1);
      end
      set_lane(o, 1'b0, 10'h3FF, 9'h1FF, 9'h1FF);
      bus.req[o] = 1'b0;
      step();
      chk($sformatf("t4_rel%0d", n), bus.grant, 0);
      bus.req[o] = 1'b1;
      step();
    end
    chk("t4_coll", bus.collision, 0);
    // non-owner write dropped, collision sticky
    do_reset();
    bus.req = 4'b0001;
    step();
    chk("t5_grant", bus.grant, 4'b0001);
    set_lane(2, 1'b1, 10'd77, 9'd77, 9'd77);
    step();
    set_lane(2, 1'b0, 10'd77, 9'd77, 9'd77);
    chk("t5_nowrite", bus.VGA_write, 0);
    chk("t5_coll", bus.collision, 1);
    step(3);
    chk("t5_coll_sticky", bus.collision, 1);
    chk("t5_x_untouched", bus.VGA_x, 0);
    // ownership limit
    do_reset();
    bus.req = 4'b0011;
    step();
    chk("t6_grant0", bus.grant, 4'b0001);
`ifdef VGA_ARB_TIMEOUT_EN
    step(15);
    chk("t6_hold0", bus.grant, 4'b0001);
    chk("t6_tmo_quiet", bus.timeout, 0);
    step();
    chk("t6_revoke0", bus.grant, 0);
    chk("t6_tmo0", bus.timeout, 1);
    step();
    chk("t6_grant1", bus.grant, 4'b0010);
    chk("t6_tmo_pulse", bus.timeout, 0);
    step(15);
    chk("t6_hold1", bus.grant, 4'b0010);
    step();
    chk("t6_revoke1", bus.grant, 0);
    chk("t6_tmo1", bus.timeout, 1);
    step(3);
    chk("t6_masked", bus.grant, 0);
    bus.req[0] = 1'b0;
    step();
    bus.req[0] = 1'b1;
    step();
    chk("t6_regrant0", bus.grant, 4'b0001);
`else
    step(40);
    chk("t6_unbounded", bus.grant, 4'b0001);
    chk("t6_tmo_tied", bus.timeout, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
